// File: rtl/tilexy_link_arb.sv
// Credit-based link arbiter: three requesters share one registered link, a
// multi-flit packet keeps the link until its last flit, fairness is round-robin.
module tilexy_link_arb #(
   parameter int W       = 679,
   parameter int CREDITS = 8,
   parameter int IDX     = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [2:0]     req_valid,
   input  logic [3*W-1:0] req_data,
   input  logic [2:0]     req_last,
   output logic [2:0]     req_ready,
   output logic           link_valid,
   output logic [W-1:0]   link_data,
   input  logic           credit_ret,
   output logic [3:0]     credits,
   output logic           stall,
   output logic           err,
   output logic [1:0]     err_id
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [3:0] CMAX = 4'(CREDITS);

   state_t         r_state;
   logic [1:0]     r_own;
   logic [1:0]     r_rr;
   logic [3:0]     r_credits;
   logic           r_link_valid;
   logic [W-1:0]   r_link_data;
   logic           r_err;

   logic           w_found;
   logic [1:0]     w_gidx;
   logic [2:0]     w_cand;
   logic [2:0]     w_grant;
   logic           w_gnt;
   logic           w_gnt_last;
   logic [W-1:0]   w_sel_data;

   // Grant search: round-robin from r_rr when idle, owner only when busy.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = 2'd0;
      w_cand  = 3'd0;
      if (r_credits != 4'd0) begin
         if (r_state == S_IDLE) begin
            for (int k = 0; k < 3; k++) begin
               w_cand = {1'b0, r_rr} + 3'(k);
               if (w_cand >= 3'd3)
                  w_cand = w_cand - 3'd3;
               if (!w_found && req_valid[w_cand[1:0]]) begin
                  w_found = 1'b1;
                  w_gidx  = w_cand[1:0];
               end
            end
         end else if (req_valid[r_own]) begin
            w_found = 1'b1;
            w_gidx  = r_own;
         end
      end
   end

   assign w_grant    = w_found ? (3'b001 << w_gidx) : 3'b000;
   assign w_gnt      = w_found;
   assign w_gnt_last = req_last[w_gidx];

   always_comb begin
      case (w_gidx)
         2'd1:    w_sel_data = req_data[1*W +: W];
         2'd2:    w_sel_data = req_data[2*W +: W];
         default: w_sel_data = req_data[0 +: W];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_own        <= 2'd0;
         r_rr         <= 2'd0;
         r_credits    <= CMAX;
         r_link_valid <= 1'b0;
         r_link_data  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_link_valid <= w_gnt;
         if (w_gnt) begin
            r_link_data <= w_sel_data;
            if (w_gnt_last) begin
               r_state <= S_IDLE;
               r_rr    <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
            end else begin
               r_state <= S_BUSY;
               r_own   <= w_gidx;
            end
         end
         // A return at full credit is a downstream protocol error, not a slot.
         case ({w_gnt, credit_ret})
            2'b10: r_credits <= r_credits - 4'd1;
            2'b01: begin
               if (r_credits == CMAX)
                  r_err <= 1'b1;
               else
                  r_credits <= r_credits + 4'd1;
            end
            default: r_credits <= r_credits;
         endcase
      end
   end

   assign req_ready  = w_grant;
   assign link_valid = r_link_valid;
   assign link_data  = r_link_data;
   assign credits    = r_credits;
   assign stall      = (r_credits == 4'd0) & (|req_valid);
   assign err        = r_err;
   assign err_id     = 2'(IDX);

endmodule

// File: tb/tb_tilexy_link_arb.sv
// Directed bench for tilexy_link_arb: round-robin order, packet ownership,
// credit exhaustion/return, overflow error and asynchronous mid-packet reset.
module tb_tilexy_link_arb;

   localparam int W = 679;

   logic           clk = 1'b0;
   logic           rst;
   logic [2:0]     req_valid;
   logic [3*W-1:0] req_data;
   logic [2:0]     req_last;
   logic [2:0]     req_ready;
   logic           link_valid;
   logic [W-1:0]   link_data;
   logic           credit_ret;
   logic           cr_drv;
   logic           tie;
   logic [3:0]     credits;
   logic           stall;
   logic           err;
   logic [1:0]     err_id;

   int n_tests = 0;
   int n_fail  = 0;

   assign credit_ret = tie ? link_valid : cr_drv;

   always #5 clk = ~clk;

   tilexy_link_arb #(.W(W), .CREDITS(8), .IDX(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .link_valid (link_valid),
      .link_data  (link_data),
      .credit_ret (credit_ret),
      .credits    (credits),
      .stall      (stall),
      .err        (err),
      .err_id     (err_id)
   );

   function automatic logic [W-1:0] dv(input int r, input int n);
      logic [W-1:0] v;
      v          = '0;
      v[W-1]     = 1'b1;
      v[W-2 -: 8] = 8'(r);
      v[15:8]    = 8'(r);
      v[7:0]     = 8'(n);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_data(input int n0, input int n1, input int n2);
      req_data = {dv(2, n2), dv(1, n1), dv(0, n0)};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [2:0] e;
      int cnt;
      rst       = 1'b1;
      req_valid = 3'b000;
      req_last  = 3'b000;
      tie       = 1'b0;
      cr_drv    = 1'b0;
      set_data(0, 0, 0);

      #12;
      chk("rst_link_valid", W'(link_valid), W'(1'b0));
      chk("rst_link_data", link_data, '0);
      chk("rst_credits", W'(credits), W'(4'd8));
      chk("rst_err", W'(err), W'(1'b0));
      chk("rst_err_id", W'(err_id), W'(2'd0));
      chk("rst_stall", W'(stall), W'(1'b0));
      chk("rst_ready", W'(req_ready), W'(3'b000));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // All three requesting single-flit packets, credit returned by link_valid
      tie       = 1'b1;
      req_valid = 3'b111;
      req_last  = 3'b111;
      set_data(1, 2, 3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         e = 3'b001 << (i % 3);
         chk("rr_ready", W'(req_ready), W'(e));
         tick();
         chk("rr_link_valid", W'(link_valid), W'(1'b1));
         chk("rr_link_data", link_data, dv(i % 3, (i % 3) + 1));
         chk("rr_credits", W'(credits), W'(4'd7));
      end
      req_valid = 3'b000;
      tick();
      chk("rr_drain_credits", W'(credits), W'(4'd8));
      chk("rr_drain_valid", W'(link_valid), W'(1'b0));
      chk("rr_hold_data", link_data, dv(2, 3));
      tie = 1'b0;

      // Move rr to 1, then requester 1 sends a 3-flit packet with a bubble
      req_valid = 3'b001;
      req_last  = 3'b001;
      set_data(5, 0, 0);
      tick();
      chk("pk_pre_data", link_data, dv(0, 5));
      chk("pk_pre_credits", W'(credits), W'(4'd7));
      req_valid = 3'b011;
      req_last  = 3'b000;
      set_data(20, 10, 0);
      @(negedge clk);
      chk("pk_f1_ready", W'(req_ready), W'(3'b010));
      tick();
      chk("pk_f1_data", link_data, dv(1, 10));
      chk("pk_f1_credits", W'(credits), W'(4'd6));
      set_data(20, 11, 0);
      @(negedge clk);
      chk("pk_f2_ready", W'(req_ready), W'(3'b010));
      tick();
      chk("pk_f2_data", link_data, dv(1, 11));
      req_valid = 3'b001;
      @(negedge clk);
      chk("pk_bubble_ready", W'(req_ready), W'(3'b000));
      chk("pk_bubble_stall", W'(stall), W'(1'b0));
      tick();
      chk("pk_bubble_valid", W'(link_valid), W'(1'b0));
      chk("pk_bubble_hold", link_data, dv(1, 11));
      chk("pk_bubble_credits", W'(credits), W'(4'd5));
      req_valid = 3'b011;
      req_last  = 3'b010;
      set_data(20, 12, 0);
      @(negedge clk);
      chk("pk_f3_ready", W'(req_ready), W'(3'b010));
      tick();
      chk("pk_f3_data", link_data, dv(1, 12));
      chk("pk_f3_credits", W'(credits), W'(4'd4));
      req_last = 3'b001;
      @(negedge clk);
      chk("pk_next_ready", W'(req_ready), W'(3'b001));
      tick();
      chk("pk_next_valid", W'(link_valid), W'(1'b1));
      chk("pk_next_data", link_data, dv(0, 20));
      chk("pk_next_credits", W'(credits), W'(4'd3));

      // Grant and credit return in the same cycle
      req_valid = 3'b001;
      req_last  = 3'b001;
      cr_drv    = 1'b1;
      @(negedge clk);
      chk("same_ready", W'(req_ready), W'(3'b001));
      tick();
      chk("same_credits", W'(credits), W'(4'd3));
      chk("same_valid", W'(link_valid), W'(1'b1));
      cr_drv    = 1'b0;
      req_valid = 3'b000;
      tick();
      chk("idle_credits", W'(credits), W'(4'd3));

      // Credit exhaustion
      do_reset();
      chk("ex_rst_credits", W'(credits), W'(4'd8));
      req_valid = 3'b001;
      req_last  = 3'b001;
      set_data(7, 0, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (link_valid)
            cnt++;
      end
      chk("ex_flit_count", W'(cnt), W'(8));
      chk("ex_credits", W'(credits), W'(4'd0));
      chk("ex_link_valid", W'(link_valid), W'(1'b0));
      chk("ex_stall", W'(stall), W'(1'b1));
      chk("ex_ready", W'(req_ready), W'(3'b000));
      cr_drv = 1'b1;
      tick();
      cr_drv = 1'b0;
      chk("ex_ret_credits", W'(credits), W'(4'd1));
      chk("ex_ret_valid", W'(link_valid), W'(1'b0));
      chk("ex_ret_ready", W'(req_ready), W'(3'b001));
      tick();
      chk("ex_one_valid", W'(link_valid), W'(1'b1));
      chk("ex_one_credits", W'(credits), W'(4'd0));
      tick();
      chk("ex_after_valid", W'(link_valid), W'(1'b0));

      // Credit overflow sets sticky err
      do_reset();
      req_valid = 3'b000;
      cr_drv    = 1'b1;
      tick();
      chk("ov_credits", W'(credits), W'(4'd8));
      chk("ov_err", W'(err), W'(1'b1));
      cr_drv    = 1'b0;
      req_valid = 3'b001;
      tick();
      chk("ov_traffic_valid", W'(link_valid), W'(1'b1));
      chk("ov_traffic_credits", W'(credits), W'(4'd7));
      chk("ov_err_sticky", W'(err), W'(1'b1));
      req_valid = 3'b000;
      tick();
      chk("ov_err_sticky2", W'(err), W'(1'b1));

      // Asynchronous reset while requester 2 owns the link
      do_reset();
      req_valid = 3'b100;
      req_last  = 3'b000;
      set_data(0, 0, 30);
      tick();
      chk("ar_f1_data", link_data, dv(2, 30));
      set_data(0, 0, 31);
      tick();
      chk("ar_f2_data", link_data, dv(2, 31));
      chk("ar_f2_credits", W'(credits), W'(4'd6));
      #2;
      rst = 1'b1;
      #1;
      chk("ar_async_valid", W'(link_valid), W'(1'b0));
      chk("ar_async_credits", W'(credits), W'(4'd8));
      chk("ar_async_data", link_data, '0);
      rst       = 1'b0;
      req_valid = 3'b111;
      req_last  = 3'b000;
      set_data(40, 41, 42);
      @(negedge clk);
      chk("ar_next_ready", W'(req_ready), W'(3'b001));
      tick();
      chk("ar_next_data", link_data, dv(0, 40));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
